regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (we/rW/din) between NREQ writeback requesters (ALU, load, mul/div).

---
 rtl/regfile_wb_arbiter_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_if.sv | 32 +++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 95 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file types for the writeback arbiter: register index and per-register mask.
package rf_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [REG_AW-1:0]   reg_idx_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    // x0 is hardwired zero: never written, never tracked
    function automatic logic is_x0(input reg_idx_t idx);
        return idx == '0;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback/issue/register-file bundle between the writeback sources, decode and the arbiter.
interface regfile_wb_arbiter_if
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 3
) ();

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*REG_AW-1:0] req_rd;
    logic [NREQ*WIDTH-1:0]  req_data;
    logic                   iss_valid;
    reg_idx_t               iss_rd;
    logic                   iss_ready;
    logic                   rf_we;
    reg_idx_t               rf_rw;
    logic [WIDTH-1:0]       rf_din;
    reg_mask_t              busy;
    logic                   wb_err;

    modport master (
        output req_valid, req_rd, req_data, iss_valid, iss_rd,
        input  req_ready, iss_ready, rf_we, rf_rw, rf_din, busy, wb_err
    );

    modport slave (
        input  req_valid, req_rd, req_data, iss_valid, iss_rd,
        output req_ready, iss_ready, rf_we, rf_rw, rf_din, busy, wb_err
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// One-hot grant arbiter. RF_ARB_RR_EN selects round-robin (pointer moves past the winner);
// otherwise fixed priority with the lowest index winning.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_gnt
);

`ifdef RF_ARB_RR_EN
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  w_ptr_nxt;
    logic [2*N-1:0] w_req_dbl;
    logic [2*N-1:0] w_gnt_dbl;
    logic [N-1:0]   w_rot_req;
    logic [N-1:0]   w_rot_gnt;

    // Rotate requests so the pointer sits at bit 0, pick lowest, rotate back
    always_comb begin
        w_req_dbl = {i_req, i_req} >> r_ptr;
        w_rot_req = w_req_dbl[N-1:0];
        w_rot_gnt = w_rot_req & (~w_rot_req + N'(1));
        w_gnt_dbl = {w_rot_gnt, w_rot_gnt} << r_ptr;
        o_gnt     = w_gnt_dbl[2*N-1:N];
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int unsigned i = 0; i < N; i++) begin
            if (o_gnt[i]) begin
                w_ptr_nxt = PW'((i + 1) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    logic w_unused;

    assign o_gnt    = i_req & (~i_req + N'(1));
    assign w_unused = ^{clk, rst, i_advance};
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources and tracks pending writes.
// Build option: RF_ARB_RR_EN (round-robin arbitration; fixed priority when undefined).
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 3
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave bus
);

    logic [NREQ-1:0]  w_req;
    logic [NREQ-1:0]  w_gnt;
    logic             w_acc;
    reg_idx_t         w_sel_rd;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_iss_ok;
    reg_mask_t        w_busy_nxt;

    logic             r_we;
    reg_idx_t         r_rw;
    logic [WIDTH-1:0] r_din;
    reg_mask_t        r_busy;
    logic             r_err;

    // No grants while reset is held
    assign w_req = bus.req_valid & {NREQ{~rst}};

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_req),
        .i_advance (w_acc),
        .o_gnt     (w_gnt)
    );

    assign w_acc         = |w_gnt;
    assign bus.req_ready = w_gnt;

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_rd   = bus.req_rd[REG_AW*i +: REG_AW];
                w_sel_data = bus.req_data[WIDTH*i +: WIDTH];
            end
        end
    end

    // WAW stall: an issue may not target a register with a write still outstanding
    assign w_iss_ok      = bus.iss_valid & (is_x0(bus.iss_rd) | ~r_busy[bus.iss_rd]);
    assign bus.iss_ready = w_iss_ok;

    // Clear from the write leaving the output stage first, so a same-edge issue wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) begin
            w_busy_nxt[r_rw] = 1'b0;
        end
        if (w_iss_ok && !is_x0(bus.iss_rd)) begin
            w_busy_nxt[bus.iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_rw   <= '0;
            r_din  <= '0;
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_we   <= w_acc & ~is_x0(w_sel_rd);
            r_busy <= w_busy_nxt;
            if (w_acc) begin
                r_rw  <= w_sel_rd;
                r_din <= w_sel_data;
            end
            if (w_acc && !is_x0(w_sel_rd) && !r_busy[w_sel_rd]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.rf_we  = r_we;
    assign bus.rf_rw  = r_rw;
    assign bus.rf_din = r_din;
    assign bus.busy   = r_busy;
    assign bus.wb_err = r_err;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then randomized traffic vs a reference model.
module tb_regfile_wb_arbiter;
    import rf_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREQ  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    regfile_wb_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Stimulus applied on the next step
    logic [NREQ-1:0]  s_valid;
    logic [4:0]       s_rd   [NREQ];
    logic [WIDTH-1:0] s_data [NREQ];
    logic             s_iss_valid;
    logic [4:0]       s_iss_rd;
    logic             s_rst;

    // Reference model
    bit               m_busy [32];
    int               m_ptr;
    bit               m_err;
    bit               m_we;
    int               m_rw;
    logic [WIDTH-1:0] m_din;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // One clock: drive, check combinational outputs, advance model, check registered outputs
    task automatic step(output int g, output logic [NREQ-1:0] rdy);
        logic [NREQ-1:0]  exp_rdy;
        bit               exp_iss;
        bit               n_we;
        int               n_rw;
        logic [WIDTH-1:0] n_din;
        rst           = s_rst;
        bus.req_valid = s_valid;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_rd[5*i +: 5]          = s_rd[i];
            bus.req_data[WIDTH*i +: WIDTH] = s_data[i];
        end
        bus.iss_valid = s_iss_valid;
        bus.iss_rd    = s_iss_rd;
        #1;
        g = -1;
        if (!s_rst) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
`ifdef RF_ARB_RR_EN
                idx = (m_ptr + k) % NREQ;
`else
                idx = k;
`endif
                if (g < 0 && s_valid[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_iss = s_iss_valid && (s_iss_rd == 0 || !m_busy[s_iss_rd]);
        check_eq("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        check_eq("iss_ready", 64'(bus.iss_ready), 64'(exp_iss));
        rdy = bus.req_ready;

        if (s_rst) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_we = 0; m_rw = 0; m_din = '0; m_ptr = 0; m_err = 0;
        end else begin
            n_we  = (g >= 0) && (s_rd[g] != 0);
            n_rw  = m_rw;
            n_din = m_din;
            if (g >= 0) begin
                n_rw  = s_rd[g];
                n_din = s_data[g];
                if (s_rd[g] != 0 && !m_busy[s_rd[g]]) m_err = 1;
                m_ptr = (g + 1) % NREQ;
            end
            if (m_we) m_busy[m_rw] = 1'b0;
            if (exp_iss && s_iss_rd != 0) m_busy[s_iss_rd] = 1'b1;
            m_we = n_we; m_rw = n_rw; m_din = n_din;
        end

        @(posedge clk);
        #1;
        check_eq("rf_we", 64'(bus.rf_we), 64'(m_we));
        if (m_we || s_rst) begin
            check_eq("rf_rw", 64'(bus.rf_rw), 64'(m_rw));
            check_eq("rf_din", 64'(bus.rf_din), 64'(m_din));
        end
        check_eq("busy", 64'(bus.busy), 64'(model_busy()));
        check_eq("wb_err", 64'(bus.wb_err), 64'(m_err));
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] rd);
        int g;
        logic [NREQ-1:0] r;
        s_iss_valid = 1'b1;
        s_iss_rd    = rd;
        step(g, r);
        s_iss_valid = 1'b0;
    endtask

    task automatic do_reset();
        int g;
        logic [NREQ-1:0] r;
        s_rst = 1'b1;
        step(g, r);
        s_rst = 1'b0;
    endtask

    initial begin
        int g;
        logic [NREQ-1:0] r;
        int q[$];
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_ptr = 0; m_err = 0; m_we = 0; m_rw = 0; m_din = '0;
        s_valid = '1; s_iss_valid = 1'b0; s_iss_rd = '0; s_rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin s_rd[i] = '0; s_data[i] = '0; end

        // Reset held two cycles with all requesters valid, then release
        step(g, r);
        step(g, r);
        check_eq("rst_ready", 64'(bus.req_ready), 64'(0));
        s_rst = 1'b0;
        step(g, r);
        check_eq("release_ready", 64'(r), 64'(3'b001));
        s_valid = '0;

        // Issue x5, writeback from requester 1
        issue(5'd5);
        s_valid = 3'b010; s_rd[1] = 5'd5; s_data[1] = 32'hDEADBEEF;
        step(g, r);
        check_eq("wb1_grant", 64'(r), 64'(3'b010));
        s_valid = '0;
        check_eq("wb1_we", 64'(bus.rf_we), 64'(1));
        check_eq("wb1_rw", 64'(bus.rf_rw), 64'(5));
        check_eq("wb1_din", 64'(bus.rf_din), 64'(32'hDEADBEEF));
        check_eq("wb1_busy_t1", 64'(bus.busy[5]), 64'(1));
        step(g, r);
        check_eq("wb1_busy_t2", 64'(bus.busy[5]), 64'(0));

        // Grant sequence with all three requesters held valid
        do_reset();
        issue(5'd1); issue(5'd2); issue(5'd3);
        s_valid = 3'b111;
        for (int i = 0; i < NREQ; i++) begin s_rd[i] = 5'(i + 1); s_data[i] = $urandom; end
        for (int k = 0; k < 6; k++) begin
            step(g, r);
`ifdef RF_ARB_RR_EN
            check_eq("rr_seq", 64'(r), 64'(1) << (k % 3));
`else
            check_eq("fp_seq", 64'(r), 64'(1));
`endif
        end
        s_valid = '0;

        // WAW stall on x7 released two cycles after its writeback is accepted
        do_reset();
        issue(5'd7);
        s_iss_valid = 1'b1; s_iss_rd = 5'd7;
        step(g, r);
        check_eq("waw_stall", 64'(bus.iss_ready), 64'(0));
        s_valid = 3'b001; s_rd[0] = 5'd7; s_data[0] = 32'h0000_0077;
        step(g, r);
        s_valid = '0;
        step(g, r);
        check_eq("waw_release", 64'(bus.iss_ready), 64'(1));
        step(g, r);
        s_iss_valid = 1'b0;
        check_eq("waw_reset_busy", 64'(bus.busy[7]), 64'(1));

        // x0 writeback suppressed; non-pending writeback raises sticky error
        s_valid = 3'b001; s_rd[0] = 5'd0; s_data[0] = 32'h1;
        step(g, r);
        s_valid = '0;
        check_eq("x0_we", 64'(bus.rf_we), 64'(0));
        check_eq("x0_err", 64'(bus.wb_err), 64'(0));
        s_valid = 3'b100; s_rd[2] = 5'd9; s_data[2] = 32'h9;
        step(g, r);
        s_valid = '0;
        check_eq("err_set", 64'(bus.wb_err), 64'(1));
        step(g, r); step(g, r); step(g, r);
        check_eq("err_sticky", 64'(bus.wb_err), 64'(1));
        do_reset();
        check_eq("err_clr", 64'(bus.wb_err), 64'(0));

        // Reset while a write sits in the output stage
        issue(5'd4);
        s_valid = 3'b001; s_rd[0] = 5'd4; s_data[0] = 32'hCAFE_0004;
        step(g, r);
        s_valid = '0;
        do_reset();
        check_eq("rst_drop_we", 64'(bus.rf_we), 64'(0));
        check_eq("rst_drop_busy", 64'(bus.busy), 64'(0));

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!s_valid[i] && $urandom_range(1, 0) == 1) begin
                    q.delete();
                    for (int j = 1; j < 32; j++) if (m_busy[j]) q.push_back(j);
                    s_valid[i] = 1'b1;
                    if (q.size() > 0 && $urandom_range(3, 0) != 0)
                        s_rd[i] = 5'(q[$urandom_range(q.size() - 1, 0)]);
                    else
                        s_rd[i] = 5'($urandom_range(31, 0));
                    s_data[i] = $urandom;
                end
            end
            s_iss_valid = 1'($urandom_range(1, 0));
            s_iss_rd    = 5'($urandom_range(31, 0));
            s_rst       = ($urandom_range(99, 0) == 0);
            step(g, r);
            if (g >= 0) s_valid[g] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
